// File: rtl/vec_mag_if.sv
// Start/done request bus for the iterative vector-magnitude unit.
// The requester drives the operands; the engine returns status and results.
interface vec_mag_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic         mode;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W:0]   result;
    logic [2*W:0] radicand;

    modport master (
        output start, mode, x, y,
        input  busy, done, result, radicand
    );

    modport slave (
        input  start, mode, x, y,
        output busy, done, result, radicand
    );
endinterface

// File: rtl/vec_mag_iter.sv
// Multi-cycle floor(sqrt(x^2 +/- y^2)) engine.
// Squares are built by shift-add, then a restoring digit-by-digit root is taken.
module vec_mag_iter #(
    parameter int unsigned W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    vec_mag_if.slave bus
);
    localparam int unsigned SW  = 2 * W;
    localparam int unsigned RW  = 2 * W + 1;
    localparam int unsigned PW  = 2 * W + 2;
    localparam int unsigned RMW = W + 2;
    localparam int unsigned TW  = W + 4;
    localparam int unsigned CW  = $clog2(W + 1);

    typedef enum logic [2:0] {S_IDLE, S_SQX, S_SQY, S_COMB, S_ROOT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    yq_q, yq_d;
    logic [W-1:0]    mpl_q, mpl_d;
    logic [SW-1:0]   mcd_q, mcd_d;
    logic [SW-1:0]   sx_q, sx_d;
    logic [SW-1:0]   sy_q, sy_d;
    logic [RW-1:0]   rad_q, rad_d;
    logic [PW-1:0]   sh_q, sh_d;
    logic [RMW-1:0]  rem_q, rem_d;
    logic [W:0]      root_q, root_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W:0]      result_q, result_d;
    logic [RW-1:0]   radicand_q, radicand_d;

    logic [TW-1:0]   rem_w, trial;
    logic [RMW-1:0]  rem_n;
    logic [W:0]      root_n;
    logic [RW-1:0]   comb_rad;

    // One restoring root step on the next radicand bit pair
    always_comb begin
        rem_w = {rem_q, sh_q[PW-1 -: 2]};
        trial = TW'({root_q, 2'b01});
        if (rem_w >= trial) begin
            rem_n  = RMW'(rem_w - trial);
            root_n = {root_q[W-1:0], 1'b1};
        end else begin
            rem_n  = RMW'(rem_w);
            root_n = {root_q[W-1:0], 1'b0};
        end
    end

    // Difference mode takes the magnitude so the radicand never underflows
    always_comb begin
        if (!mode_q)
            comb_rad = RW'(sx_q) + RW'(sy_q);
        else if (sx_q >= sy_q)
            comb_rad = RW'(sx_q - sy_q);
        else
            comb_rad = RW'(sy_q - sx_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        yq_d       = yq_q;
        mpl_d      = mpl_q;
        mcd_d      = mcd_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        rad_d      = rad_q;
        sh_d       = sh_q;
        rem_d      = rem_q;
        root_d     = root_q;
        result_d   = result_q;
        radicand_d = radicand_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    yq_d    = bus.y;
                    mpl_d   = bus.x;
                    mcd_d   = SW'(bus.x);
                    sx_d    = '0;
                    sy_d    = '0;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = S_SQX;
                end
            end
            S_SQX: begin
                if (mpl_q[0]) sx_d = sx_q + mcd_q;
                mpl_d = mpl_q >> 1;
                mcd_d = mcd_q << 1;
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    mpl_d   = yq_q;
                    mcd_d   = SW'(yq_q);
                    state_d = S_SQY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SQY: begin
                if (mpl_q[0]) sy_d = sy_q + mcd_q;
                mpl_d = mpl_q >> 1;
                mcd_d = mcd_q << 1;
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    state_d = S_COMB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_COMB: begin
                rad_d   = comb_rad;
                sh_d    = PW'(comb_rad);
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = S_ROOT;
            end
            S_ROOT: begin
                rem_d  = rem_n;
                root_d = root_n;
                sh_d   = sh_q << 2;
                if (cnt_q == CW'(W)) begin
                    cnt_d      = '0;
                    result_d   = root_n;
                    radicand_d = rad_q;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            yq_q       <= '0;
            mpl_q      <= '0;
            mcd_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            rad_q      <= '0;
            sh_q       <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            radicand_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            yq_q       <= yq_d;
            mpl_q      <= mpl_d;
            mcd_q      <= mcd_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            rad_q      <= rad_d;
            sh_q       <= sh_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            radicand_q <= radicand_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.radicand = radicand_q;
endmodule

// File: tb/tb_vec_mag_iter.sv
// Bench for vec_mag_iter: W=8 vector table, multi-cycle corner sequences,
// and random sweeps on W=4 and W=12 instances sharing one stimulus/check path.
module tb_vec_mag_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_v, mode_v;
    logic [15:0] x_v, y_v;
    int          sel;

    vec_mag_if #(.W(8))  b8 ();
    vec_mag_if #(.W(4))  b4 ();
    vec_mag_if #(.W(12)) b12 ();

    vec_mag_iter #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    vec_mag_iter #(.W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    vec_mag_iter #(.W(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12.slave));

    assign b8.start  = start_v && (sel == 0);
    assign b8.mode   = mode_v;
    assign b8.x      = x_v[7:0];
    assign b8.y      = y_v[7:0];
    assign b4.start  = start_v && (sel == 1);
    assign b4.mode   = mode_v;
    assign b4.x      = x_v[3:0];
    assign b4.y      = y_v[3:0];
    assign b12.start = start_v && (sel == 2);
    assign b12.mode  = mode_v;
    assign b12.x     = x_v[11:0];
    assign b12.y     = y_v[11:0];

    logic        busy_m, done_m;
    logic [16:0] res_m;
    logic [32:0] rad_m;

    always_comb begin
        busy_m = 1'b0;
        done_m = 1'b0;
        res_m  = '0;
        rad_m  = '0;
        case (sel)
            0: begin busy_m = b8.busy;  done_m = b8.done;  res_m = 17'(b8.result);  rad_m = 33'(b8.radicand);  end
            1: begin busy_m = b4.busy;  done_m = b4.done;  res_m = 17'(b4.result);  rad_m = 33'(b4.radicand);  end
            2: begin busy_m = b12.busy; done_m = b12.done; res_m = 17'(b12.result); rad_m = 33'(b12.radicand); end
            default: ;
        endcase
    end

    typedef struct { bit m; int x; int y; longint rad; longint res; } vec_t;
    typedef struct { longint rad; longint res; } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic longint isqrt(longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic exp_t model(bit m, longint xv, longint yv);
        exp_t   e;
        longint a = xv * xv;
        longint b = yv * yv;
        if (!m)          e.rad = a + b;
        else if (a >= b) e.rad = a - b;
        else             e.rad = b - a;
        e.res = isqrt(e.rad);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_job(bit m, int xv, int yv);
        mode_v  = m;
        x_v     = 16'(xv);
        y_v     = 16'(yv);
        start_v = 1'b1;
        sb.push_back(model(m, longint'(xv), longint'(yv)));
        tick();
        start_v = 1'b0;
        check("busy_after_start", longint'(busy_m), 1);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=done required=no_done");
            return;
        end
        e = sb.pop_front();
        check("result", longint'(res_m), e.res);
        check("radicand", longint'(rad_m), e.rad);
    endtask

    task automatic wait_done(int w);
        int lat   = 0;
        int drops = 0;
        while (!done_m && lat < 200) begin
            tick();
            lat++;
            if (!busy_m) drops++;
        end
        if (!done_m) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_200");
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        check("latency", longint'(lat), longint'(3 * w + 2));
        check("busy_held", longint'(drops), 0);
        check_out();
        tick();
        check("done_one_cycle", longint'(done_m), 0);
        check("busy_low_after_done", longint'(busy_m), 0);
    endtask

    vec_t tbl[8];

    initial begin
        int n_done;

        tbl[0] = '{1'b0,   3,   4,     25,   5};
        tbl[1] = '{1'b0, 255, 255, 130050, 360};
        tbl[2] = '{1'b0,   0,   0,      0,   0};
        tbl[3] = '{1'b1,   5,   3,     16,   4};
        tbl[4] = '{1'b1,   3,   5,     16,   4};
        tbl[5] = '{1'b1,   7,   7,      0,   0};
        tbl[6] = '{1'b0,   6,   8,    100,  10};
        tbl[7] = '{1'b1, 255,   0,  65025, 255};

        sel = 0; start_v = 1'b0; mode_v = 1'b0; x_v = '0; y_v = '0; rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", longint'(busy_m), 0);
        check("rst_done", longint'(done_m), 0);
        check("rst_result", longint'(res_m), 0);
        check("rst_radicand", longint'(rad_m), 0);

        // Reset dominates a coincident start
        start_v = 1'b1; x_v = 16'd3; y_v = 16'd4;
        tick();
        check("rst_wins_busy", longint'(busy_m), 0);
        start_v = 1'b0;
        rst_n   = 1'b1;
        tick();
        check("idle_no_start", longint'(busy_m), 0);

        for (int i = 0; i < 8; i++) begin
            start_job(tbl[i].m, tbl[i].x, tbl[i].y);
            wait_done(8);
            check("tbl_result_const", longint'(res_m), tbl[i].res);
            check("tbl_radicand_const", longint'(rad_m), tbl[i].rad);
        end

        // Starts inside the job, on the last ROOT edge and in DONE are ignored
        start_job(1'b0, 3, 4);
        repeat (4) tick();
        start_v = 1'b1; mode_v = 1'b1; x_v = 16'd9; y_v = 16'd9;
        tick();
        start_v = 1'b0;
        check("ign_busy_mid", longint'(busy_m), 1);
        repeat (20) tick();
        start_v = 1'b1; mode_v = 1'b0; x_v = 16'd1; y_v = 16'd1;
        tick();
        check("ign_done_edge26", longint'(done_m), 1);
        check_out();
        tick();
        check("ign_done_low", longint'(done_m), 0);
        check("ign_busy_low", longint'(busy_m), 0);
        check("ign_result_hold", longint'(res_m), 5);
        start_v = 1'b0;
        start_job(1'b0, 6, 8);
        wait_done(8);

        // Reset mid-job aborts with cleared outputs
        start_job(1'b0, 200, 100);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if (sb.size() != 0) void'(sb.pop_front());
        check("abort_busy", longint'(busy_m), 0);
        check("abort_done", longint'(done_m), 0);
        check("abort_result", longint'(res_m), 0);
        check("abort_radicand", longint'(rad_m), 0);
        n_done = 0;
        repeat (40) begin
            tick();
            if (done_m || busy_m) n_done++;
        end
        check("abort_quiet", longint'(n_done), 0);
        start_job(1'b0, 6, 8);
        wait_done(8);
        check("after_abort_result", longint'(res_m), 10);

        sel = 1;
        tick();
        start_job(1'b0, 15, 15);
        wait_done(4);
        check("w4_max_radicand", longint'(rad_m), 450);
        check("w4_max_result", longint'(res_m), 21);
        for (int i = 0; i < 16; i++) begin
            start_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            wait_done(4);
        end

        sel = 2;
        tick();
        start_job(1'b0, 4095, 4095);
        wait_done(12);
        start_job(1'b1, 4095, 0);
        wait_done(12);
        for (int i = 0; i < 16; i++) begin
            start_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            wait_done(12);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
